regfile_access_ctrl: RTL and testbench



---
 rtl/regfile_access_ctrl.sv | 146 ++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : regfile_access_ctrl
// Description : Write-buffered, read-forwarding access controller for a 32x64
//               register file.
// Revision    : 1.0
// =============================================================================
module regfile_access_ctrl #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 5,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_valid,
    output logic                       rd_ready,
    input  logic [ADDR_W-1:0]          rd_addr1,
    input  logic [ADDR_W-1:0]          rd_addr2,
    output logic                       rd_resp_valid,
    output logic [DATA_W-1:0]          rd_data1,
    output logic [DATA_W-1:0]          rd_data2,
    output logic [$clog2(WBUF_DEPTH):0] wbuf_count,
    output logic [ADDR_W-1:0]          ReadReg1,
    output logic [ADDR_W-1:0]          ReadReg2,
    input  logic [DATA_W-1:0]          ReadData1,
    input  logic [DATA_W-1:0]          ReadData2,
    output logic                       RegWrite,
    output logic [ADDR_W-1:0]          WriteReg,
    output logic [DATA_W-1:0]          WriteData
);

    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH   = CNT_W'(WBUF_DEPTH);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

    logic [ADDR_W-1:0] r_buf_addr [WBUF_DEPTH];
    logic [DATA_W-1:0] r_buf_data [WBUF_DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    logic              r_s1_valid;
    logic              r_hit1;
    logic              r_hit2;
    logic [DATA_W-1:0] r_fwd1;
    logic [DATA_W-1:0] r_fwd2;
    logic [DATA_W:0]   w_lk1;
    logic [DATA_W:0]   w_lk2;

    assign wr_ready   = (r_count < C_DEPTH) && !Reset;
    assign rd_ready   = !Reset;
    assign w_push     = wr_valid && wr_ready;
    assign w_pop      = (r_count != '0);
    assign wbuf_count = r_count;

    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_buf_addr[r_tail] <= wr_addr;
            r_buf_data[r_tail] <= wr_data;
        end
    end

    // Occupancy is judged before the pop, so a drain never frees space for
    // the write accepted in the same cycle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + C_PTR_ONE;
            if (w_pop)  r_head <= r_head + C_PTR_ONE;
            if (w_push && !w_pop)      r_count <= r_count + C_CNT_ONE;
            else if (!w_push && w_pop) r_count <= r_count - C_CNT_ONE;
            RegWrite <= w_pop;
            if (w_pop) begin
                WriteReg  <= r_buf_addr[r_head];
                WriteData <= r_buf_data[r_head];
            end
        end
    end

    // Later matches override earlier ones: in-flight, then FIFO oldest to
    // youngest, then the write being accepted this cycle.
    function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] addr);
        logic [DATA_W:0]  res;
        logic [PTR_W-1:0] idx;
        res = '0;
        if (RegWrite && (WriteReg == addr)) res = {1'b1, WriteData};
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            idx = r_head + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (r_buf_addr[idx] == addr))
                res = {1'b1, r_buf_data[idx]};
        end
        if (w_push && (wr_addr == addr)) res = {1'b1, wr_data};
        return res;
    endfunction

    always_comb begin
        w_lk1 = fwd_lookup(rd_addr1);
        w_lk2 = fwd_lookup(rd_addr2);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_s1_valid    <= 1'b0;
            ReadReg1      <= '0;
            ReadReg2      <= '0;
            r_hit1        <= 1'b0;
            r_hit2        <= 1'b0;
            r_fwd1        <= '0;
            r_fwd2        <= '0;
            rd_resp_valid <= 1'b0;
            rd_data1      <= '0;
            rd_data2      <= '0;
        end else begin
            r_s1_valid <= rd_valid;
            if (rd_valid) begin
                ReadReg1 <= rd_addr1;
                ReadReg2 <= rd_addr2;
                r_hit1   <= w_lk1[DATA_W];
                r_hit2   <= w_lk2[DATA_W];
                r_fwd1   <= w_lk1[DATA_W-1:0];
                r_fwd2   <= w_lk2[DATA_W-1:0];
            end
            rd_resp_valid <= r_s1_valid;
            if (r_s1_valid) begin
                rd_data1 <= r_hit1 ? r_fwd1 : ReadData1;
                rd_data2 <= r_hit2 ? r_fwd2 : ReadData2;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_access_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : tb_regfile_access_ctrl
// Description : Self-checking bench for regfile_access_ctrl with a register
//               file model and an architectural scoreboard.
// Revision    : 1.0
// =============================================================================
module tb_regfile_access_ctrl;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic              rd_resp_valid;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic [2:0]        wbuf_count;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;

    logic [DATA_W-1:0] rf [32];
    logic              init_rf;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               wq[$];
    logic [DATA_W-1:0] model_val [32];
    logic              s1_v, s2_v;
    logic [DATA_W-1:0] s1_d1, s1_d2, s2_d1, s2_d2;
    logic              exp_rw;
    logic [ADDR_W-1:0] exp_wreg;
    logic [DATA_W-1:0] exp_wdata;

    regfile_access_ctrl #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .WBUF_DEPTH (DEPTH)
    ) dut (
        .Clock         (clk),
        .Reset         (rst),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_addr1      (rd_addr1),
        .rd_addr2      (rd_addr2),
        .rd_resp_valid (rd_resp_valid),
        .rd_data1      (rd_data1),
        .rd_data2      (rd_data2),
        .wbuf_count    (wbuf_count),
        .ReadReg1      (ReadReg1),
        .ReadReg2      (ReadReg2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .RegWrite      (RegWrite),
        .WriteReg      (WriteReg),
        .WriteData     (WriteData)
    );

    always #5 clk = ~clk;

    // Register file: combinational read, commit at the edge while RegWrite.
    assign ReadData1 = rf[ReadReg1];
    assign ReadData2 = rf[ReadReg2];
    always @(posedge clk) begin
        if (init_rf) begin
            for (int i = 0; i < 32; i++) rf[i] <= {$urandom, $urandom};
        end else if (RegWrite) begin
            rf[WriteReg] <= WriteData;
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wr_valid = 1'b0;
        rd_valid = 1'b0;
    endtask

    // Architectural scoreboard: a read sees every write accepted at or before it.
    task automatic scoreboard;
        wr_t  w;
        logic exp_wrdy;
        forever begin
            @(negedge clk);
            if (rst) begin
                wq.delete();
                s1_v = 1'b0; s2_v = 1'b0;
                exp_rw = 1'b0; exp_wreg = '0; exp_wdata = '0;
                for (int i = 0; i < 32; i++) model_val[i] = rf[i];
            end else begin
                exp_wrdy = (wq.size() < DEPTH);
                checks++;
                if (wr_ready !== exp_wrdy) begin
                    errors++; $display("FAIL sb_wr_ready: got %b expected %b", wr_ready, exp_wrdy);
                end
                checks++;
                if (rd_ready !== 1'b1) begin
                    errors++; $display("FAIL sb_rd_ready: got %b expected 1", rd_ready);
                end
                checks++;
                if (wbuf_count !== 3'(wq.size())) begin
                    errors++; $display("FAIL sb_wbuf_count: got %0d expected %0d", wbuf_count, wq.size());
                end
                checks++;
                if ({RegWrite, WriteReg, WriteData} !== {exp_rw, exp_wreg, exp_wdata}) begin
                    errors++;
                    $display("FAIL sb_write_port: got rw=%b reg=%0d data=%h expected rw=%b reg=%0d data=%h",
                             RegWrite, WriteReg, WriteData, exp_rw, exp_wreg, exp_wdata);
                end
                checks++;
                if (rd_resp_valid !== s2_v) begin
                    errors++; $display("FAIL sb_resp_valid: got %b expected %b", rd_resp_valid, s2_v);
                end
                if (s2_v) begin
                    checks++;
                    if ({rd_data1, rd_data2} !== {s2_d1, s2_d2}) begin
                        errors++;
                        $display("FAIL sb_rd_data: got %h/%h expected %h/%h", rd_data1, rd_data2, s2_d1, s2_d2);
                    end
                end
                s2_v = s1_v; s2_d1 = s1_d1; s2_d2 = s1_d2;
                if (wq.size() > 0) begin
                    w = wq.pop_front();
                    exp_rw = 1'b1; exp_wreg = w.addr; exp_wdata = w.data;
                end else begin
                    exp_rw = 1'b0;
                end
                if (wr_valid && exp_wrdy) begin
                    wq.push_back({wr_addr, wr_data});
                    model_val[wr_addr] = wr_data;
                end
                s1_v = rd_valid;
                if (rd_valid) begin
                    s1_d1 = model_val[rd_addr1];
                    s1_d2 = model_val[rd_addr2];
                end
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1 init_rf = 1'b0;
        @(negedge clk);
        checks++;
        if ({wr_ready, rd_ready, wbuf_count, RegWrite, rd_resp_valid} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got wr_ready=%b rd_ready=%b count=%0d rw=%b rv=%b expected all 0",
                     wr_ready, rd_ready, wbuf_count, RegWrite, rd_resp_valid);
        end
        checks++;
        if ({WriteReg, WriteData, ReadReg1, ReadReg2, rd_data1, rd_data2} !== '0) begin
            errors++;
            $display("FAIL reset_data: got wreg=%0d wdata=%h rr1=%0d rr2=%0d d1=%h d2=%h expected 0",
                     WriteReg, WriteData, ReadReg1, ReadReg2, rd_data1, rd_data2);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({wr_ready, rd_ready} !== 2'b11) begin
            errors++; $display("FAIL reset_release: got %b%b expected 11", wr_ready, rd_ready);
        end
    endtask

    task automatic test_basic;
        next_cycle();
        wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 64'hDEAD_BEEF_0000_0001;
        next_cycle();
        idle();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({RegWrite, WriteReg, WriteData} !== {1'b1, 5'd3, 64'hDEAD_BEEF_0000_0001}) begin
            errors++;
            $display("FAIL basic_drain: got rw=%b reg=%0d data=%h expected rw=1 reg=3 data=deadbeef00000001",
                     RegWrite, WriteReg, WriteData);
        end
        repeat (3) next_cycle();
        rd_valid = 1'b1; rd_addr1 = 5'd3; rd_addr2 = 5'd0;
        next_cycle();
        idle();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({rd_resp_valid, rd_data1} !== {1'b1, 64'hDEAD_BEEF_0000_0001}) begin
            errors++;
            $display("FAIL basic_read: got valid=%b data=%h expected valid=1 data=deadbeef00000001",
                     rd_resp_valid, rd_data1);
        end
    endtask

    task automatic test_forwarding;
        next_cycle();
        wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 64'h11;
        next_cycle();
        wr_valid = 1'b0;
        rd_valid = 1'b1; rd_addr1 = 5'd7; rd_addr2 = 5'd7;
        next_cycle();
        idle();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({rd_resp_valid, rd_data1, rd_data2} !== {1'b1, 64'h11, 64'h11}) begin
            errors++;
            $display("FAIL fwd_fifo: got valid=%b d1=%h d2=%h expected 1/11/11", rd_resp_valid, rd_data1, rd_data2);
        end
        next_cycle();
        wr_valid = 1'b1; wr_addr = 5'd9; wr_data = 64'h22;
        rd_valid = 1'b1; rd_addr1 = 5'd9; rd_addr2 = 5'd7;
        next_cycle();
        idle();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({rd_resp_valid, rd_data1, rd_data2} !== {1'b1, 64'h22, 64'h11}) begin
            errors++;
            $display("FAIL fwd_same_cycle: got valid=%b d1=%h d2=%h expected 1/22/11", rd_resp_valid, rd_data1, rd_data2);
        end
    endtask

    task automatic test_youngest;
        logic [DATA_W-1:0] vals [3];
        vals[0] = 64'hA; vals[1] = 64'hB; vals[2] = 64'hC;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            wr_valid = 1'b1; wr_addr = 5'd4; wr_data = vals[i];
        end
        next_cycle();
        wr_valid = 1'b0;
        rd_valid = 1'b1; rd_addr1 = 5'd4; rd_addr2 = 5'd4;
        next_cycle();
        idle();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({rd_resp_valid, rd_data1, rd_data2} !== {1'b1, 64'hC, 64'hC}) begin
            errors++;
            $display("FAIL youngest: got valid=%b d1=%h d2=%h expected 1/c/c", rd_resp_valid, rd_data1, rd_data2);
        end
    endtask

    task automatic test_burst_wrap;
        logic [DATA_W-1:0] vals [11];
        for (int i = 1; i <= 6; i++) begin
            next_cycle();
            wr_valid = 1'b1; wr_addr = 5'(i); wr_data = {$urandom, $urandom};
            @(negedge clk);
            checks++;
            if (wr_ready !== 1'b1 || $isunknown(wbuf_count) || wbuf_count > 3'd1) begin
                errors++;
                $display("FAIL burst6: got wr_ready=%b count=%0d expected wr_ready=1 count<=1", wr_ready, wbuf_count);
            end
        end
        for (int i = 1; i <= 10; i++) begin
            next_cycle();
            vals[i] = {$urandom, $urandom};
            wr_valid = 1'b1; wr_addr = 5'(i); wr_data = vals[i];
        end
        next_cycle();
        idle();
        repeat (3) next_cycle();
        for (int a = 1; a <= 10; a++) begin
            rd_valid = 1'b1; rd_addr1 = 5'(a); rd_addr2 = 5'(11 - a);
            next_cycle();
            rd_valid = 1'b0;
            next_cycle();
            @(negedge clk);
            checks++;
            if ({rd_resp_valid, rd_data1, rd_data2} !== {1'b1, vals[a], vals[11-a]}) begin
                errors++;
                $display("FAIL wrap_read addr=%0d: got valid=%b d1=%h d2=%h expected 1/%h/%h",
                         a, rd_resp_valid, rd_data1, rd_data2, vals[a], vals[11-a]);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_burst;
        logic [DATA_W-1:0] pre11, pre12;
        idle();
        repeat (3) next_cycle();
        pre11 = rf[11];
        pre12 = rf[12];
        for (int i = 10; i <= 12; i++) begin
            wr_valid = 1'b1; wr_addr = 5'(i); wr_data = {$urandom, $urandom};
            next_cycle();
        end
        idle();
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({RegWrite, wbuf_count, rd_resp_valid, wr_ready, rd_ready} !== 7'b0) begin
            errors++;
            $display("FAIL midreset_immediate: got rw=%b count=%0d rv=%b wrdy=%b rrdy=%b expected all 0",
                     RegWrite, wbuf_count, rd_resp_valid, wr_ready, rd_ready);
        end
        next_cycle();
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({RegWrite, wbuf_count} !== 4'b0) begin
                errors++; $display("FAIL midreset_no_drain: got rw=%b count=%0d expected 0/0", RegWrite, wbuf_count);
            end
            next_cycle();
        end
        rd_valid = 1'b1; rd_addr1 = 5'd12; rd_addr2 = 5'd11;
        next_cycle();
        idle();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({rd_resp_valid, rd_data1, rd_data2} !== {1'b1, pre12, pre11}) begin
            errors++;
            $display("FAIL midreset_read: got valid=%b d1=%h d2=%h expected 1/%h/%h",
                     rd_resp_valid, rd_data1, rd_data2, pre12, pre11);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            next_cycle();
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_addr  = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            wr_data  = {$urandom, $urandom};
            rd_valid = ($urandom_range(0, 2) != 0);
            rd_addr1 = 5'($urandom_range(0, 7));
            rd_addr2 = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            if (i == 200) begin
                #1 rst = 1'b1;
                next_cycle();
                #1 rst = 1'b0;
            end
        end
        next_cycle();
        idle();
        repeat (4) next_cycle();
        @(negedge clk);
        checks++;
        if ({RegWrite, wbuf_count, rd_resp_valid} !== 5'b0) begin
            errors++;
            $display("FAIL random_quiesce: got rw=%b count=%0d rv=%b expected 0/0/0", RegWrite, wbuf_count, rd_resp_valid);
        end
    endtask

    initial begin
        rst = 1'b1; init_rf = 1'b1;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_valid = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
        fork
            scoreboard();
        join_none
        test_reset();
        test_basic();
        test_forwarding();
        test_youngest();
        test_burst_wrap();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
